// File: rtl/matrix_scan.sv
// Row/column shift-register LED matrix scanner with BPP-bit binary-code modulation.
// Double-buffered pixel store; front/back exchange only on the frame boundary.
module matrix_scan #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int BPP       = 2,
    parameter int BASE_TIME = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [BPP-1:0]          wr_data,
    input  logic                    swap,
    output logic                    swap_pending,
    output logic                    frame_start,
    output logic                    rclk,
    output logic                    rsdi,
    output logic                    oeb,
    output logic                    csdi,
    output logic                    cclk,
    output logic                    le
);

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int PW   = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int NPIX = 2 * ROWS * COLS;
    localparam int IW   = $clog2(NPIX);
    localparam int DW   = $clog2((BASE_TIME << (BPP - 1)) + 1);

    typedef enum logic [2:0] {ROWSEL_D, ROWSEL_C, SHIFT, LATCH, DISPLAY} state_t;

    state_t                    state;
    logic [RW-1:0]             row;
    logic [CW-1:0]             col;
    logic [PW-1:0]             plane;
    logic                      phase;
    logic [DW-1:0]             disp_cnt;
    logic                      front;
    logic [NPIX-1:0][BPP-1:0]  fb;

    logic          boundary, xchg, wr_buf, wr_ok, last_plane, last_row;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [BPP-1:0] pix;

    // Flat store: buffer index is the most significant part of the pixel address.
    always_comb begin
        boundary   = (state == ROWSEL_D) && (row == '0);
        xchg       = boundary && swap_pending;
        wr_buf     = xchg ? front : ~front;
        wr_ok      = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
        wr_idx     = IW'((int'(wr_buf) * ROWS + int'(wr_row)) * COLS + int'(wr_col));
        rd_idx     = IW'((int'(front) * ROWS + int'(row)) * COLS + int'(col));
        pix        = fb[rd_idx];
        last_plane = (plane == PW'(BPP - 1));
        last_row   = (row == RW'(ROWS - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fb <= '0;
        else if (wr_ok) fb[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ROWSEL_D;
            row          <= '0;
            col          <= '0;
            plane        <= '0;
            phase        <= 1'b0;
            disp_cnt     <= '0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
            frame_start  <= 1'b0;
            rclk         <= 1'b0;
            rsdi         <= 1'b0;
            oeb          <= 1'b1;
            csdi         <= 1'b0;
            cclk         <= 1'b0;
            le           <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            rclk        <= 1'b0;
            cclk        <= 1'b0;
            le          <= 1'b0;
            oeb         <= 1'b1;
            csdi        <= 1'b0;

            // A swap seen on the boundary itself only arms the next boundary.
            if (boundary) begin
                if (swap_pending) front <= ~front;
                swap_pending <= swap;
            end else if (swap) begin
                swap_pending <= 1'b1;
            end

            case (state)
                ROWSEL_D: begin
                    rsdi        <= (row == '0);
                    frame_start <= boundary;
                    state       <= ROWSEL_C;
                end
                ROWSEL_C: begin
                    rclk  <= 1'b1;
                    col   <= CW'(COLS - 1);
                    phase <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (!phase) begin
                        csdi  <= pix[plane];
                        phase <= 1'b1;
                    end else begin
                        csdi  <= csdi;
                        cclk  <= 1'b1;
                        phase <= 1'b0;
                        if (col == '0) state <= LATCH;
                        else           col   <= col - 1'b1;
                    end
                end
                LATCH: begin
                    le       <= 1'b1;
                    disp_cnt <= DW'((BASE_TIME << plane) - 1);
                    state    <= DISPLAY;
                end
                DISPLAY: begin
                    oeb <= 1'b0;
                    if (disp_cnt == '0) begin
                        if (last_plane) begin
                            plane <= '0;
                            row   <= last_row ? '0 : row + 1'b1;
                            state <= ROWSEL_D;
                        end else begin
                            plane <= plane + 1'b1;
                            col   <= CW'(COLS - 1);
                            phase <= 1'b0;
                            state <= SHIFT;
                        end
                    end else begin
                        disp_cnt <= disp_cnt - 1'b1;
                    end
                end
                default: state <= ROWSEL_D;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: per-frame scoreboard of shifted bits and display lengths
// against a two-buffer reference, plus swap timing, reset and out-of-range writes.
module tb_matrix_scan;

    localparam int ROWS  = 2;
    localparam int COLS  = 4;
    localparam int BPP   = 2;
    localparam int BT    = 4;
    localparam int FRAME = ROWS * ((2 * COLS + 3 + BT) + (2 * COLS + 1 + (BT << 1)));

    logic clk, reset;
    logic wr_en, swap;
    logic [0:0] wr_row;
    logic [1:0] wr_col;
    logic [BPP-1:0] wr_data;
    logic swap_pending, frame_start, rclk, rsdi, oeb, csdi, cclk, le;

    logic wr2_en, swap2;
    logic [1:0] wr2_row, wr2_col, wr2_data;
    logic swap_pending2, frame_start2, rclk2, rsdi2, oeb2, csdi2, cclk2, le2;

    matrix_scan #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP), .BASE_TIME(BT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .swap(swap), .swap_pending(swap_pending),
        .frame_start(frame_start), .rclk(rclk), .rsdi(rsdi), .oeb(oeb),
        .csdi(csdi), .cclk(cclk), .le(le)
    );

    matrix_scan #(.ROWS(3), .COLS(3), .BPP(2), .BASE_TIME(2)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr2_en), .wr_row(wr2_row), .wr_col(wr2_col),
        .wr_data(wr2_data), .swap(swap2), .swap_pending(swap_pending2),
        .frame_start(frame_start2), .rclk(rclk2), .rsdi(rsdi2), .oeb(oeb2),
        .csdi(csdi2), .cclk(cclk2), .le(le2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [BPP-1:0] mb [2][ROWS][COLS];
    int mf;
    bit mpend;

    bit bitq[$];
    int lenq[$];
    int n_le, n_rclk, n_cclk, n_fs, low_cnt;
    logic prev_oeb, prev_cclk, prev_le, prev_rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) mb[b][r][c] = '0;
        mf = 0; mpend = 0;
        bitq.delete(); lenq.delete();
        prev_oeb = 1'b1; prev_cclk = 1'b0; prev_le = 1'b0; prev_rclk = 1'b0;
        low_cnt = 0;
    endtask

    task automatic push_frame();
        for (int r = 0; r < ROWS; r++)
            for (int p = 0; p < BPP; p++) begin
                for (int c = COLS - 1; c >= 0; c--) bitq.push_back(mb[mf][r][c][p]);
                lenq.push_back(BT << p);
            end
    endtask

    task automatic mon();
        if (cclk && !prev_cclk) begin
            n_cclk++;
            if (bitq.size() == 0) check("csdi_extra_bit", bitq.size(), 1);
            else check("csdi", csdi, bitq.pop_front());
        end
        if (!oeb) low_cnt++;
        if (oeb && !prev_oeb) begin
            if (lenq.size() == 0) check("oeb_extra_window", lenq.size(), 1);
            else check("oeb_len", low_cnt, lenq.pop_front());
            low_cnt = 0;
        end
        if (le && !prev_le) begin
            n_le++;
            check("cclk_per_plane", n_cclk, COLS);
            n_cclk = 0;
        end
        if (rclk && !prev_rclk) begin
            check("rsdi_at_rclk", rsdi, (n_rclk == 0));
            n_rclk++;
        end
        prev_oeb = oeb; prev_cclk = cclk; prev_le = le; prev_rclk = rclk;
    endtask

    // Entered on the frame_start sample; returns on the next frame_start sample.
    task automatic run_frame(input int swap_at, input int wr_at, input int wr_r,
                             input int wr_c, input int wr_d);
        push_frame();
        n_le = 0; n_rclk = 0; n_cclk = 0; n_fs = 0;
        for (int k = 0; k <= FRAME; k++) begin
            if (k > 0) begin
                @(negedge clk);
                mon();
                if (k < FRAME) begin
                    if (frame_start) n_fs++;
                    check("swap_pending", swap_pending, mpend);
                end
            end
            if (k < FRAME) begin
                wr_en   = (k == wr_at);
                wr_row  = 1'(wr_r);
                wr_col  = 2'(wr_c);
                wr_data = BPP'(wr_d);
                swap    = (k == swap_at);
                if (k == wr_at && k < FRAME - 1) mb[mf ^ 1][wr_r][wr_c] = BPP'(wr_d);
                if (k == swap_at && k < FRAME - 1) mpend = 1;
            end
        end
        if (mpend) begin mf ^= 1; mpend = 0; end
        if (swap_at == FRAME - 1) mpend = 1;
        if (wr_at == FRAME - 1) mb[mf ^ 1][wr_r][wr_c] = BPP'(wr_d);
        wr_en = 1'b0; swap = 1'b0;
        check("frame_start_period", frame_start, 1);
        check("swap_pending_boundary", swap_pending, mpend);
        check("frame_start_extra", n_fs, 0);
        check("le_per_frame", n_le, ROWS * BPP);
        check("rclk_per_frame", n_rclk, ROWS);
        check("bits_left", bitq.size(), 0);
        check("windows_left", lenq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oeb"}, oeb, 1);
        check({tag, "_rclk"}, rclk, 0);
        check({tag, "_rsdi"}, rsdi, 0);
        check({tag, "_csdi"}, csdi, 0);
        check({tag, "_cclk"}, cclk, 0);
        check({tag, "_le"}, le, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_swap_pending"}, swap_pending, 0);
    endtask

    initial begin
        int waited, hits, rises;
        logic p2;
        reset = 1'b0; wr_en = 1'b0; swap = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        wr2_en = 1'b0; swap2 = 1'b0; wr2_row = '0; wr2_col = '0; wr2_data = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check("first_frame_start", frame_start, 1);

        run_frame(-1, -1, 0, 0, 0);           // all-zero frame
        run_frame(10, 2, 0, 3, 2);            // write (0,3)=2, swap mid-frame
        run_frame(FRAME - 1, 5, 1, 0, 3);     // grayscale shown; swap on boundary deferred
        run_frame(-1, FRAME - 1, 0, 0, 1);    // still old front; write on boundary
        run_frame(20, -1, 0, 0, 0);           // shows (1,0)=3 only
        run_frame(-1, -1, 0, 0, 0);           // shows (0,3)=2 and (0,0)=1

        waited = 0;
        while (oeb !== 1'b0 && waited < 40) begin @(negedge clk); waited++; end
        check("reach_display", oeb, 0);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("restart_frame_start", frame_start, 1);
        run_frame(-1, -1, 0, 0, 0);

        // second instance: out-of-range writes must never appear
        swap2 = 1'b1;
        @(negedge clk);
        swap2 = 1'b0;
        waited = 0;
        while (swap_pending2 !== 1'b0 && waited < 200) begin @(negedge clk); waited++; end
        check("dut2_first_swap", swap_pending2, 0);
        wr2_en = 1'b1; wr2_row = 2'd3; wr2_col = 2'd1; wr2_data = 2'd3;
        @(negedge clk);
        wr2_row = 2'd0; wr2_col = 2'd3;
        @(negedge clk);
        wr2_en = 1'b0; swap2 = 1'b1;
        @(negedge clk);
        swap2 = 1'b0;
        hits = 0; rises = 0; p2 = cclk2;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cclk2 && !p2) begin
                rises++;
                if (csdi2 !== 1'b0) hits++;
            end
            p2 = cclk2;
        end
        check("dut2_oor_lit_bits", hits, 0);
        check("dut2_cclk_seen", (rises > 0), 1);
        check("dut2_second_swap", swap_pending2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
